// File: rtl/ase_pkg.sv
// Shared CCI-P tracking types: length encoding, statistic selector, table entry.
package ase_pkg;

  typedef logic [1:0] ccip_len_t;

  // Widest timestamp a table entry can hold; narrower TS_W zero-extends.
  localparam int unsigned TRACK_TS_MAX_W = 64;

  typedef enum logic [2:0] {
    STAT_OUTSTANDING = 3'd0,
    STAT_REQ_COUNT   = 3'd1,
    STAT_RSP_COUNT   = 3'd2,
    STAT_LAT_MIN     = 3'd3,
    STAT_LAT_MAX     = 3'd4,
    STAT_LAT_SUM     = 3'd5,
    STAT_ERR         = 3'd6,
    STAT_RSVD        = 3'd7
  } stat_sel_t;

  typedef struct packed {
    logic                      valid;
    ccip_len_t                 remaining;
    logic [TRACK_TS_MAX_W-1:0] ts;
  } track_entry_t;

endpackage

// File: rtl/ccip_txn_chan_tracker.sv
// One channel: tag table, timeout scanner and statistics.
// Ports: request/response strobes with tags, shared timestamp, clear;
// outputs are the registered statistics and sticky error state.
module ccip_txn_chan_tracker
  import ase_pkg::*;
#(
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [TS_W-1:0]  now,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  input  ccip_len_t        req_len,
  input  logic             rsp_valid,
  input  logic [TAG_W-1:0] rsp_tag,
  output logic [TAG_W:0]   outstanding,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] rsp_count,
  output logic [TS_W-1:0]  lat_min,
  output logic [TS_W-1:0]  lat_max,
  output logic [CNT_W-1:0] lat_sum,
  output logic [2:0]       err_flags,
  output logic [TAG_W-1:0] err_tag
);

  localparam int unsigned DEPTH = 2 ** TAG_W;

  track_entry_t     entries [DEPTH];
  logic [TAG_W-1:0] scan_ptr;

  track_entry_t     rsp_entry;
  track_entry_t     req_entry;
  track_entry_t     scan_entry;
  logic             orphan;
  logic             retire;
  logic             dup;
  logic             alloc;
  logic             timed_out;
  logic [TS_W-1:0]  latency;
  logic [TS_W-1:0]  scan_age;
  logic [CNT_W:0]   sum_ext;

  // Response is resolved before the request so a same-tag retire frees the slot.
  always_comb begin
    rsp_entry  = entries[rsp_tag];
    req_entry  = entries[req_tag];
    scan_entry = entries[scan_ptr];
    orphan     = 1'b0;
    retire     = 1'b0;
    dup        = 1'b0;
    alloc      = 1'b0;
    if (enable && rsp_valid) begin
      if (!rsp_entry.valid)               orphan = 1'b1;
      else if (rsp_entry.remaining == '0) retire = 1'b1;
    end
    if (enable && req_valid) begin
      if (req_entry.valid && !(retire && (rsp_tag == req_tag))) dup   = 1'b1;
      else                                                      alloc = 1'b1;
    end
    latency   = now - TS_W'(rsp_entry.ts);
    scan_age  = now - TS_W'(scan_entry.ts);
    timed_out = scan_entry.valid && (scan_age > TS_W'(TIMEOUT));
    sum_ext   = {1'b0, lat_sum} + (CNT_W + 1)'(latency);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      outstanding <= '0;
      scan_ptr    <= '0;
    end else begin
      scan_ptr <= scan_ptr + TAG_W'(1);
      if (enable && rsp_valid && rsp_entry.valid) begin
        if (retire) entries[rsp_tag].valid     <= 1'b0;
        else        entries[rsp_tag].remaining <= rsp_entry.remaining - 2'd1;
      end
      if (alloc) begin
        entries[req_tag] <= '{valid: 1'b1, remaining: req_len, ts: TRACK_TS_MAX_W'(now)};
      end
      case ({alloc, retire})
        2'b10:   outstanding <= outstanding + (TAG_W + 1)'(1);
        2'b01:   outstanding <= outstanding - (TAG_W + 1)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count <= '0;
      rsp_count <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      err_flags <= '0;
      err_tag   <= '0;
    end else if (clear) begin
      req_count <= '0;
      rsp_count <= '0;
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      err_flags <= '0;
      err_tag   <= '0;
    end else begin
      if (enable && req_valid && (req_count != '1)) req_count <= req_count + CNT_W'(1);
      if (retire) begin
        if (rsp_count != '1) rsp_count <= rsp_count + CNT_W'(1);
        if (latency < lat_min) lat_min <= latency;
        if (latency > lat_max) lat_max <= latency;
        lat_sum <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
      end
      // Later assignments win the captured tag: dup > orphan > timeout.
      if (timed_out) begin
        err_flags[2] <= 1'b1;
        err_tag      <= scan_ptr;
      end
      if (orphan) begin
        err_flags[1] <= 1'b1;
        err_tag      <= rsp_tag;
      end
      if (dup) begin
        err_flags[0] <= 1'b1;
        err_tag      <= req_tag;
      end
    end
  end

endmodule

// File: rtl/ccip_txn_tracker.sv
// CCI-P transaction tracker top: reset synchroniser, timestamp, per-channel
// trackers, statistics read mux/register and error summary.
// Ports: CCI-P request/response strobes and tags per channel, enable, clear,
// statistics read port (1-cycle latency), err_any.
module ccip_txn_tracker
  import ase_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      SoftReset_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*TAG_W-1:0]   req_tag,
  input  logic [NUM_CH*2-1:0]       req_len,
  input  logic [NUM_CH-1:0]         rsp_valid,
  input  logic [NUM_CH*TAG_W-1:0]   rsp_tag,
  input  logic                      stat_rd_en,
  input  logic [$clog2(NUM_CH)-1:0] stat_ch,
  input  logic [2:0]                stat_sel,
  output logic                      stat_rd_valid,
  output logic [63:0]               stat_rd_data,
  output logic                      err_any
);

  logic            rst_meta;
  logic            rst_sync_n;
  logic [TS_W-1:0] now;

  logic [TAG_W:0]   ch_outstanding [NUM_CH];
  logic [CNT_W-1:0] ch_req_count   [NUM_CH];
  logic [CNT_W-1:0] ch_rsp_count   [NUM_CH];
  logic [TS_W-1:0]  ch_lat_min     [NUM_CH];
  logic [TS_W-1:0]  ch_lat_max     [NUM_CH];
  logic [CNT_W-1:0] ch_lat_sum     [NUM_CH];
  logic [2:0]       ch_err_flags   [NUM_CH];
  logic [TAG_W-1:0] ch_err_tag     [NUM_CH];
  logic [63:0]      rd_mux;

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) {rst_meta, rst_sync_n} <= '0;
    else              {rst_meta, rst_sync_n} <= {1'b1, rst_meta};
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) now <= '0;
    else             now <= now + TS_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ccip_txn_chan_tracker #(
      .TAG_W   (TAG_W),
      .TS_W    (TS_W),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_sync_n),
      .enable      (enable),
      .clear       (clear),
      .now         (now),
      .req_valid   (req_valid[c]),
      .req_tag     (req_tag[c*TAG_W +: TAG_W]),
      .req_len     (req_len[c*2 +: 2]),
      .rsp_valid   (rsp_valid[c]),
      .rsp_tag     (rsp_tag[c*TAG_W +: TAG_W]),
      .outstanding (ch_outstanding[c]),
      .req_count   (ch_req_count[c]),
      .rsp_count   (ch_rsp_count[c]),
      .lat_min     (ch_lat_min[c]),
      .lat_max     (ch_lat_max[c]),
      .lat_sum     (ch_lat_sum[c]),
      .err_flags   (ch_err_flags[c]),
      .err_tag     (ch_err_tag[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    if (32'(stat_ch) < NUM_CH) begin
      case (stat_sel_t'(stat_sel))
        STAT_OUTSTANDING: rd_mux = 64'(ch_outstanding[stat_ch]);
        STAT_REQ_COUNT:   rd_mux = 64'(ch_req_count[stat_ch]);
        STAT_RSP_COUNT:   rd_mux = 64'(ch_rsp_count[stat_ch]);
        STAT_LAT_MIN:     rd_mux = 64'(ch_lat_min[stat_ch]);
        STAT_LAT_MAX:     rd_mux = 64'(ch_lat_max[stat_ch]);
        STAT_LAT_SUM:     rd_mux = 64'(ch_lat_sum[stat_ch]);
        STAT_ERR:         rd_mux = 64'({ch_err_tag[stat_ch], ch_err_flags[stat_ch]});
        default:          rd_mux = '0;
      endcase
    end
  end

  always_comb begin
    err_any = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) err_any = err_any | (|ch_err_flags[i]);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      stat_rd_valid <= 1'b0;
      stat_rd_data  <= '0;
    end else begin
      stat_rd_valid <= stat_rd_en;
      stat_rd_data  <= stat_rd_en ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_ccip_txn_tracker.sv
module tb_ccip_txn_tracker;

  localparam int NCH   = 2;
  localparam int DEPTH = 64;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        SoftReset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [11:0] req_tag = '0;
  logic [3:0]  req_len = '0;
  logic [1:0]  rsp_valid = '0;
  logic [11:0] rsp_tag = '0;
  logic        stat_rd_en = 1'b0;
  logic        stat_ch = 1'b0;
  logic [2:0]  stat_sel = '0;
  logic        stat_rd_valid;
  logic [63:0] stat_rd_data;
  logic        err_any;

  ccip_txn_tracker #(
    .NUM_CH  (2),
    .TAG_W   (6),
    .TS_W    (32),
    .CNT_W   (32),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .SoftReset_n   (SoftReset_n),
    .enable        (enable),
    .clear         (clear),
    .req_valid     (req_valid),
    .req_tag       (req_tag),
    .req_len       (req_len),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .stat_rd_en    (stat_rd_en),
    .stat_ch       (stat_ch),
    .stat_sel      (stat_sel),
    .stat_rd_valid (stat_rd_valid),
    .stat_rd_data  (stat_rd_data),
    .err_any       (err_any)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  bit dir_rd = 1'b0;
  logic [3:0] rot = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [NCH][DEPTH];
  bit [1:0]    m_rem   [NCH][DEPTH];
  bit [31:0]   m_ts    [NCH][DEPTH];
  int unsigned m_out   [NCH];
  bit [31:0]   m_req [NCH], m_rsp [NCH], m_min [NCH], m_max [NCH], m_sum [NCH];
  bit          m_dup [NCH], m_orph [NCH], m_to [NCH];
  bit [5:0]    m_tag [NCH];
  bit [31:0]   m_now;
  int          rel_edges;
  bit          exp_rd_valid;
  bit [63:0]   exp_rd_data;

  task automatic clear_stats(input int c);
    m_req[c] = 0; m_rsp[c] = 0; m_sum[c] = 0; m_max[c] = 0; m_min[c] = 32'hFFFF_FFFF;
    m_dup[c] = 0; m_orph[c] = 0; m_to[c] = 0; m_tag[c] = 0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int t = 0; t < DEPTH; t++) begin
        m_valid[c][t] = 0; m_rem[c][t] = 0; m_ts[c][t] = 0;
      end
      m_out[c] = 0;
      clear_stats(c);
    end
    m_now = 0;
    exp_rd_valid = 0;
    exp_rd_data = 0;
  endtask

  function automatic bit [63:0] stat_value(input int c, input int sel);
    case (sel)
      0: return 64'(m_out[c]);
      1: return 64'(m_req[c]);
      2: return 64'(m_rsp[c]);
      3: return 64'(m_min[c]);
      4: return 64'(m_max[c]);
      5: return 64'(m_sum[c]);
      6: return 64'({m_tag[c], m_to[c], m_orph[c], m_dup[c]});
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit model_err_any();
    bit e = 0;
    for (int c = 0; c < NCH; c++) e = e | m_dup[c] | m_orph[c] | m_to[c];
    return e;
  endfunction

  always @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      model_reset();
      rel_edges = 0;
    end else if (rel_edges < 2) begin
      rel_edges++;
      exp_rd_valid = 0;
      exp_rd_data = 0;
    end else begin
      exp_rd_valid = stat_rd_en;
      exp_rd_data  = stat_rd_en ? stat_value(int'(stat_ch), int'(stat_sel)) : 64'd0;
      for (int c = 0; c < NCH; c++) begin
        bit [5:0]  sp, t;
        bit        retire, orph, dup, to_hit;
        bit [31:0] lat;
        bit [32:0] s;
        retire = 0; orph = 0; dup = 0; lat = 0;
        sp = m_now[5:0];
        to_hit = m_valid[c][sp] && ((m_now - m_ts[c][sp]) > TO);
        if (enable && rsp_valid[c]) begin
          t = rsp_tag[c*6 +: 6];
          if (!m_valid[c][t]) orph = 1;
          else if (m_rem[c][t] == 0) begin
            retire = 1;
            lat = m_now - m_ts[c][t];
            m_valid[c][t] = 0;
            m_out[c]--;
          end else m_rem[c][t]--;
        end
        if (enable && req_valid[c]) begin
          t = req_tag[c*6 +: 6];
          if (m_valid[c][t]) dup = 1;
          else begin
            m_valid[c][t] = 1; m_rem[c][t] = req_len[c*2 +: 2]; m_ts[c][t] = m_now; m_out[c]++;
          end
        end
        if (clear) clear_stats(c);
        else begin
          if (enable && req_valid[c] && m_req[c] != 32'hFFFF_FFFF) m_req[c]++;
          if (retire) begin
            if (m_rsp[c] != 32'hFFFF_FFFF) m_rsp[c]++;
            if (lat < m_min[c]) m_min[c] = lat;
            if (lat > m_max[c]) m_max[c] = lat;
            s = 33'(m_sum[c]) + 33'(lat);
            m_sum[c] = s[32] ? 32'hFFFF_FFFF : s[31:0];
          end
          if (to_hit) begin m_to[c] = 1;   m_tag[c] = sp; end
          if (orph)   begin m_orph[c] = 1; m_tag[c] = rsp_tag[c*6 +: 6]; end
          if (dup)    begin m_dup[c] = 1;  m_tag[c] = req_tag[c*6 +: 6]; end
        end
      end
      m_now++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 64'(stat_rd_valid), 64'(exp_rd_valid));
      check("rd_data", stat_rd_data, exp_rd_data);
      check("err_any", 64'(err_any), 64'(model_err_any()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    if (!dir_rd) begin
      stat_rd_en = 1'b1;
      {stat_ch, stat_sel} = rot;
      rot++;
    end
    @(negedge clk);
    req_valid = '0;
    rsp_valid = '0;
    clear = 1'b0;
  endtask

  task automatic req(input int c, input int tag, input int len);
    req_valid[c] = 1'b1;
    req_tag[c*6 +: 6] = 6'(tag);
    req_len[c*2 +: 2] = 2'(len);
  endtask

  task automatic rsp(input int c, input int tag);
    rsp_valid[c] = 1'b1;
    rsp_tag[c*6 +: 6] = 6'(tag);
  endtask

  task automatic rd_lit(input int c, input int sel, input logic [63:0] exp, input string name);
    dir_rd = 1'b1;
    stat_rd_en = 1'b1;
    stat_ch = 1'(c);
    stat_sel = 3'(sel);
    tick();
    check(name, stat_rd_data, exp);
    dir_rd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset rd_valid", 64'(stat_rd_valid), 64'd0);
    check("reset err_any", 64'(err_any), 64'd0);
    SoftReset_n = 1'b1;
    enable = 1'b1;
    repeat (4) tick();
    rd_lit(0, 3, 64'hFFFF_FFFF, "reset lat_min");

    // 4CL read, tag 5, 10-cycle response spacing -> latency 40
    req(0, 5, 3); tick();
    rd_lit(0, 0, 64'd1, "t1 outstanding 1");
    for (int r = 0; r < 4; r++) begin
      repeat (r == 0 ? 8 : 9) tick();
      rsp(0, 5); tick();
    end
    rd_lit(0, 0, 64'd0, "t1 outstanding 0");
    rd_lit(0, 2, 64'd1, "t1 rsp_count");
    rd_lit(0, 3, 64'd40, "t1 lat_min");
    rd_lit(0, 4, 64'd40, "t1 lat_max");
    rd_lit(0, 5, 64'd40, "t1 lat_sum");
    check("model pin lat_max", 64'(m_max[0]), 64'd40);

    // duplicate tag 5
    req(0, 5, 0); tick();
    req(0, 5, 0); tick();
    check("t2 err_any", 64'(err_any), 64'd1);
    rd_lit(0, 0, 64'd1, "t2 outstanding");
    rd_lit(0, 6, 64'd41, "t2 err word");
    rd_lit(0, 1, 64'd3, "t2 req_count");
    rsp(0, 5); tick();
    clear = 1'b1; tick();
    check("t2 err_any cleared", 64'(err_any), 64'd0);
    rd_lit(0, 3, 64'hFFFF_FFFF, "t2 lat_min after clear");
    rd_lit(0, 6, 64'd0, "t2 err word cleared");

    // orphan tag 9
    rsp(0, 9); tick();
    rd_lit(0, 6, 64'd74, "t3 err word");
    rd_lit(0, 2, 64'd0, "t3 rsp_count");
    rd_lit(0, 0, 64'd0, "t3 outstanding");
    check("model pin orphan", 64'({m_tag[0], m_to[0], m_orph[0], m_dup[0]}), 64'd74);
    clear = 1'b1; tick();

    // timeout on ch1 tag 3
    req(1, 3, 0); tick();
    n = 0;
    while (!err_any && n < 200) begin
      tick();
      n++;
    end
    check("t4 timeout window", 64'(n >= 65 && n <= 128), 64'd1);
    rd_lit(1, 6, 64'd28, "t4 err word");
    rsp(1, 3); tick();
    clear = 1'b1; tick();
    check("t4 err_any cleared", 64'(err_any), 64'd0);

    // same-cycle retire and reallocate tag 7
    req(0, 7, 0); tick();
    repeat (3) tick();
    rsp(0, 7); req(0, 7, 0); tick();
    rd_lit(0, 6, 64'd0, "t5 no dup");
    rd_lit(0, 0, 64'd1, "t5 outstanding");
    rd_lit(0, 2, 64'd1, "t5 rsp_count");
    rsp(0, 7); tick();
    rd_lit(0, 0, 64'd0, "t5 outstanding 0");

    // disabled traffic is ignored
    enable = 1'b0;
    req(0, 20, 0); rsp(1, 30); tick();
    enable = 1'b1;
    rd_lit(0, 1, 64'd2, "en req_count");
    rd_lit(1, 6, 64'd0, "en no orphan");
    rd_lit(0, 0, 64'd0, "en outstanding");

    // reset mid-flight
    req(0, 10, 1); tick();
    req(0, 11, 1); tick();
    req(0, 12, 1); tick();
    rd_lit(0, 0, 64'd3, "t6 outstanding 3");
    tick();
    #2 SoftReset_n = 1'b0;
    #1;
    check("t6 async rd_valid", 64'(stat_rd_valid), 64'd0);
    check("t6 async rd_data", stat_rd_data, 64'd0);
    check("t6 async err_any", 64'(err_any), 64'd0);
    tick();
    tick();
    SoftReset_n = 1'b1;
    repeat (3) tick();
    rd_lit(0, 0, 64'd0, "t6 outstanding 0");
    rd_lit(0, 1, 64'd0, "t6 req_count 0");
    rsp(0, 10); tick();
    rd_lit(0, 6, 64'd82, "t6 orphan old tag");
    check("t6 err_any", 64'(err_any), 64'd1);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccip_txn_tracker.md
# ccip_txn_tracker

Parametrised, synthesizable CCI-P transaction tracker that sits beside the AFU on the CCI-P request/response channels. It matches each request to its response(s) by mdata tag and keeps per-channel outstanding counts and latency statistics. It also flags duplicate tags, orphan responses and timed-out requests. Software and the testbench read results through a one-cycle-latency statistics port; this replaces post-processing of text transaction logs.

## Interface
- NUM_CH, 2: number of independent request/response channel pairs tracked (e.g. ch0 = C0 read, ch1 = C1 write).
- TAG_W, 6: mdata LSBs used as the tracking tag; the table holds 2^TAG_W entries per channel.
- TS_W, 32: free-running timestamp width.
- CNT_W, 32: statistics counter width.
- TIMEOUT, 4096: request age in cycles beyond which an entry is flagged timed out.

- clk  in  1  clock.
- SoftReset_n  in  1  asynchronous, active-low reset.
- enable  in  1  tracking enable; when low, new requests and responses are ignored.
- clear  in  1  single-cycle pulse; zeroes statistics and error flags.
- req_valid  in  NUM_CH  request issued on channel c.
- req_tag  in  NUM_CH*TAG_W  request tag per channel.
- req_len  in  NUM_CH*2  ccip_len_t per channel; expected responses = len+1.
- rsp_valid  in  NUM_CH  response received on channel c (one per CL).
- rsp_tag  in  NUM_CH*TAG_W  response tag per channel.
- stat_rd_en  in  1  statistics read strobe.
- stat_ch  in  $clog2(NUM_CH)  channel to read.
- stat_sel  in  3  statistic selector.
- stat_rd_valid  out  1  read data valid.
- stat_rd_data  out  64  read data, zero-extended.
- err_any  out  1  OR of all sticky error flags.

## Operation
- Per-channel table entry: valid, remaining-CL counter (2 bits), issue timestamp (TS_W).
- Request with the tag entry invalid: set valid, remaining = len, timestamp = now; increment outstanding and req_count.
- Request with the tag entry valid: set sticky dup_err and capture the tag; the entry is not overwritten; req_count still increments.
- Response with the tag entry invalid: set sticky orphan_err and capture the tag; no other state changes.
- Response with remaining > 0: decrement remaining.
- Response with remaining == 0: retire the entry, decrement outstanding, increment rsp_count, compute latency = now − ts modulo 2^TS_W, then update min, max and sum.
- Same-cycle response and request on the same channel and tag: the response is processed first. If it retires the entry, the request allocates cleanly; otherwise dup_err is set.
- Timeout scanner: a pointer visits one entry per cycle per channel and wraps at 2^TAG_W. A valid entry with age > TIMEOUT sets sticky timeout_err and captures the tag; the entry stays valid.
- Counters saturate at all-ones. The outstanding count never exceeds 2^TAG_W.
- stat_sel encoding: 0 outstanding, 1 req_count, 2 rsp_count, 3 lat_min, 4 lat_max, 5 lat_sum, 6 {TAG_W captured tag, 3'b timeout/orphan/dup}, 7 reads as zero.
- clear zeroes counts, sum, max and errors, and sets min to all-ones. It does not touch the table or outstanding. If clear and an update occur in the same cycle, the update is discarded and clear wins.

## Timing
- Reset values:
  - stat_rd_valid = 0, stat_rd_data = 0, err_any = 0.
  - All table entries invalid; all counters 0; lat_min all-ones.
  - Timestamp and scan pointers 0.
- Reset is asserted asynchronously and released synchronously (two-flop synchroniser on deassert). Reset mid-transaction drops all table entries.
- Table and statistics update on the clock edge after a valid input. stat_rd_data returns the value of that same edge's registered state.
- Read latency: stat_rd_valid pulses 1 cycle after stat_rd_en, and reads back-to-back every cycle.
- A read issued in the cycle after an update returns the updated value.
- Worst-case timeout detection: TIMEOUT + 2^TAG_W cycles after issue.
- Timestamp wrap is handled by modular subtraction. Latencies ≥ 2^TS_W are not distinguished.

## Structure
- In ase_pkg:
  - stat_sel_t enum.
  - track_entry_t struct {valid, remaining, ts}.
  - Existing ccip_len_t reused.
- Sub-module ccip_txn_chan_tracker, generated NUM_CH times; holds one table, its scanner and its statistics.
- The top level holds the timestamp, clear distribution and the read mux/register.

## Test plan
- Read on ch0: tag 5, len 4CL at t=100; 4 responses with the last at t=140. Expected: outstanding 1→0, rsp_count 1, lat_min = lat_max = 40.
- Same tag 5 issued twice without a response. Expected: dup_err set, stat_sel 6 returns tag 5, err_any = 1, outstanding 1.
- Response tag 9 with no request. Expected: orphan_err set; counts unchanged.
- Request tag 3 with no response and TIMEOUT = 64. Expected: timeout_err within 64 + 64 cycles, with tag 3 captured.
- Same-cycle 1CL response retiring tag 7 and a new request tag 7. Expected: no dup_err, outstanding 1, rsp_count 1.
- 3 outstanding requests, then SoftReset_n pulsed low mid-flight. Expected: outstanding 0 and all outputs 0 immediately. A later response to an old tag sets orphan_err.
